// File: rtl/quadrature_decoder.sv
// quadrature_decoder: A/B encoder to one-cycle step_en/step_up strobes with sync, resolution select and illegal-jump flag.
// Optional per-channel glitch filter is compiled in when QUAD_GLITCH_FILTER_EN is defined.
module quadrature_decoder #(
    parameter int SYNC_STAGES   = 2,
    parameter int RESOLUTION    = 4,
    parameter int FILTER_CYCLES = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enc_a,
    input  logic enc_b,
    input  logic err_clear,
    output logic step_en,
    output logic step_up,
    output logic dir,
    output logic err
);
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("quadrature_decoder: SYNC_STAGES must be 2..4");
    end
    if (RESOLUTION != 1 && RESOLUTION != 2 && RESOLUTION != 4) begin : g_bad_res
        $error("quadrature_decoder: RESOLUTION must be 1, 2 or 4");
    end
    if (FILTER_CYCLES < 2 || FILTER_CYCLES > 15) begin : g_bad_filt
        $error("quadrature_decoder: FILTER_CYCLES must be 2..15");
    end

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             ab;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], enc_a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], enc_b};
        end
    end

`ifdef QUAD_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    logic [1:0] raw;
    assign raw = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
    for (genvar i = 0; i < 2; i++) begin : g_filt
        logic [CW-1:0] cnt;
        logic          q;
        // Counts consecutive samples that disagree with the held output.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= '0;
                q   <= 1'b0;
            end else if (raw[i] == q) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
                cnt <= '0;
                q   <= raw[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        assign ab[i] = q;
    end
`else
    assign ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
`endif

    logic       init;
    logic [1:0] prev_ab;
    logic [1:0] delta;
    logic [1:0] pos_new;
    logic [1:0] pos_old;
    logic       legal;
    logic       illegal;
    logic       up;
    logic       admit;

    assign delta   = ab ^ prev_ab;
    assign legal   = !init && (delta == 2'b01 || delta == 2'b10);
    assign illegal = !init && delta == 2'b11;
    // Position along the forward cycle 00,10,11,01 so "up" is a +1 step mod 4.
    assign pos_new = {ab[0], ab[1] ^ ab[0]};
    assign pos_old = {prev_ab[0], prev_ab[1] ^ prev_ab[0]};
    assign up      = (pos_new - pos_old) == 2'd1;
    assign admit   = legal && (RESOLUTION == 4 ? 1'b1 :
                               RESOLUTION == 2 ? delta[1] :
                               ({prev_ab, ab} == 4'b0010 || {prev_ab, ab} == 4'b1000));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            init    <= 1'b1;
            prev_ab <= 2'b00;
            step_en <= 1'b0;
            step_up <= 1'b0;
            dir     <= 1'b0;
            err     <= 1'b0;
        end else begin
            init    <= 1'b0;
            prev_ab <= ab;
            step_en <= admit;
            step_up <= admit && up;
            if (legal) dir <= up;
            err     <= illegal || (err && !err_clear);
        end
    end
endmodule

// File: tb/tb_quadrature_decoder.sv
// tb_quadrature_decoder: three resolutions side by side, checked every cycle against a transition-table model.
module tb_quadrature_decoder;
    localparam int S = 2;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    logic enc_a = 1'b0;
    logic enc_b = 1'b0;
    logic err_clear = 1'b0;
    logic [2:0] en, up, dr, er;

    always #5 clock = ~clock;

    quadrature_decoder #(.SYNC_STAGES(S), .RESOLUTION(4)) u_r4 (
        .clock(clock), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .err_clear(err_clear),
        .step_en(en[0]), .step_up(up[0]), .dir(dr[0]), .err(er[0]));
    quadrature_decoder #(.SYNC_STAGES(S), .RESOLUTION(2)) u_r2 (
        .clock(clock), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .err_clear(err_clear),
        .step_en(en[1]), .step_up(up[1]), .dir(dr[1]), .err(er[1]));
    quadrature_decoder #(.SYNC_STAGES(S), .RESOLUTION(1)) u_r1 (
        .clock(clock), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .err_clear(err_clear),
        .step_en(en[2]), .step_up(up[2]), .dir(dr[2]), .err(er[2]));

    int vectors = 0;
    int miscompares = 0;

    int          res_of [3] = '{4, 2, 1};
    logic [1:0]  fwd [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0]  q [$];
    logic [1:0]  prev_m;
    bit          init_m, in_rst;
    logic [2:0]  m_en, m_up;
    logic        m_dir, m_err;
    logic [15:0] m_cnt [3];
    logic [15:0] d_cnt [3];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        in_rst = 1;
        q.delete();
        repeat (S) q.push_back(2'b00);
        init_m = 1;
        prev_m = 2'b00;
        m_en = '0;
        m_up = '0;
        m_dir = 0;
        m_err = 0;
    endtask

    task automatic model_edge(input logic [1:0] v, input logic clr);
        logic [1:0] ab;
        int i_old;
        bit fstep;
        i_old = 0;
        if (!in_rst) begin
            q.push_back(v);
            ab = q.pop_front();
            m_en = '0;
            m_up = '0;
            if (init_m) begin
                init_m = 0;
                m_err = m_err & ~clr;
            end else if ((ab ^ prev_m) == 2'b11) begin
                m_err = 1;
            end else begin
                m_err = m_err & ~clr;
                if (ab != prev_m) begin
                    for (int i = 0; i < 4; i++) if (fwd[i] == prev_m) i_old = i;
                    fstep = (fwd[(i_old + 1) % 4] == ab);
                    m_dir = fstep;
                    for (int r = 0; r < 3; r++)
                        if (res_of[r] == 4 || (res_of[r] == 2 && ab[1] != prev_m[1]) ||
                            (res_of[r] == 1 && ((prev_m == 2'b00 && ab == 2'b10) || (prev_m == 2'b10 && ab == 2'b00)))) begin
                            m_en[r] = 1;
                            m_up[r] = fstep;
                            m_cnt[r] += fstep ? 16'd1 : 16'hFFFF;
                        end
                end
            end
            prev_m = ab;
        end
    endtask

    task automatic check_all();
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("step_en[res%0d]", res_of[r]), en[r], m_en[r]);
            chk($sformatf("step_up[res%0d]", res_of[r]), up[r], m_up[r]);
            chk($sformatf("dir[res%0d]", res_of[r]), dr[r], m_dir);
            chk($sformatf("err[res%0d]", res_of[r]), er[r], m_err);
            if (en[r] === 1'b1) d_cnt[r] += (up[r] === 1'b1) ? 16'd1 : 16'hFFFF;
        end
    endtask

    task automatic step(input logic [1:0] v, input logic clr);
        enc_a = v[1];
        enc_b = v[0];
        err_clear = clr;
        @(posedge clock);
        model_edge(v, clr);
        #1 check_all();
    endtask

    task automatic hold(input logic [1:0] v, input int n);
        repeat (n) step(v, 1'b0);
    endtask

    task automatic do_reset(input logic [1:0] v);
        reset_n = 1'b0;
        model_reset();
        #1 check_all();
        step(v, 1'b0);
        step(v, 1'b0);
        reset_n = 1'b1;
        in_rst = 0;
    endtask

    initial begin
        logic [15:0] b0, b1, b2;
        logic [1:0] cur;
        int lat, r, k;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = '0;
            d_cnt[i] = '0;
        end
        #1 do_reset(2'b00);
        hold(2'b00, 8);
        for (int i = 1; i <= 4; i++) hold(fwd[i % 4], 8);
        chk("cnt_after_fwd", d_cnt[0], 16'd4);
        chk("dir_after_fwd", dr[0], 16'd1);
        repeat (2) for (int i = 3; i >= 0; i--) hold(fwd[i], 8);
        chk("cnt_after_rev", d_cnt[0], 16'hFFFC);
        chk("dir_after_rev", dr[0], 16'd0);
        b1 = d_cnt[1];
        b2 = d_cnt[2];
        repeat (3) for (int i = 1; i <= 4; i++) hold(fwd[i % 4], 4);
        chk("res1_three_cycles", d_cnt[2] - b2, 16'd3);
        chk("res2_three_cycles", d_cnt[1] - b1, 16'd6);
        b0 = d_cnt[0];
        hold(2'b11, 6);
        chk("err_after_jump", er[0], 16'd1);
        chk("no_strobe_on_jump", d_cnt[0], b0);
        step(2'b11, 1'b1);
        hold(2'b11, 2);
        chk("err_cleared", er[0], 16'd0);
        repeat (S + 1) step(2'b00, 1'b1);
        hold(2'b00, 3);
        chk("err_set_wins", er[0], 16'd1);
        step(2'b00, 1'b1);
        hold(2'b10, 4);
        hold(2'b11, 4);
        do_reset(2'b11);
        hold(2'b11, 6);
        step(2'b01, 1'b0);
        lat = 1;
        while (en[0] !== 1'b1 && lat < 20) begin
            step(2'b01, 1'b0);
            lat++;
        end
        chk("latency_after_reset", 16'(lat), 16'(S + 1));
        chk("latency_strobe_up", up[0], 16'd1);
        hold(2'b01, 4);
        cur = 2'b01;
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset(cur);
            end else begin
                if (r < 45) begin
                    k = 0;
                    for (int i = 0; i < 4; i++) if (fwd[i] == cur) k = i;
                    cur = fwd[(k + ($urandom_range(0, 1) ? 1 : 3)) % 4];
                end else if (r < 49) begin
                    cur = ~cur;
                end
                step(cur, $urandom_range(0, 15) == 0);
            end
        end
        for (int i = 0; i < 3; i++) chk($sformatf("final_count[res%0d]", res_of[i]), d_cnt[i], m_cnt[i]);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
